multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 The block SHALL have parameter OPCODE_W, default 5, meaning opcode field width; it SHALL be >= 5.
REQ-002 The block SHALL have parameter STACK_DEPTH, default 8, meaning the maximum call nesting depth; it SHALL be >= 1.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the width of the retired-instruction counter.
REQ-004 The block SHALL have the following ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction word available.
- opcode  in  OPCODE_W  opcode of the offered instruction.
- zero  in  1  ALU zero flag, sampled in EXECUTE.
- mem_ready  in  1  data memory completes the access this cycle.
- instr_ready  out  1  block accepts the instruction this cycle.
- ir_write  out  1  latch the instruction register.
- pc_inc  out  1  PC += 1.
- pc_load  out  1  load PC from target.
- regWrite  out  1  register file write enable.
- memoryRead  out  1  data memory read request.
- memoryWrite  out  1  data memory write request.
- branch  out  1  branch instruction in EXECUTE.
- jump  out  1  JMP in EXECUTE.
- call  out  1  CALL in EXECUTE: push return address.
- ret  out  1  RET in EXECUTE: pop return address.
- trap  out  1  sticky fault.
- trap_cause  out  2  fault code: 0 none, 1 illegal opcode, 2 stack overflow, 3 stack underflow.
- depth  out  $clog2(STACK_DEPTH+1)  current call depth.
- retired  out  CNT_W  retired-instruction count.
- busy  out  1  high in every state except FETCH.

Function
REQ-005 The FSM SHALL have the states FETCH, DECODE, EXECUTE, MEM, WB and TRAP.
REQ-006 In FETCH, instr_ready SHALL be 1; the instruction is accepted when instr_valid=1.
REQ-007 On acceptance, ir_write and pc_inc SHALL pulse for exactly 1 cycle, the opcode SHALL be registered, and the FSM SHALL move to DECODE.
REQ-008 DECODE SHALL last exactly 1 cycle and SHALL classify the opcode:
- 0-13: ALU.
- 14: JMP.
- 15: BEQ.
- 16: BNE.
- 17: CALL.
- 18: RET.
- 19: LD.
- 20: ST.
- All other values: illegal; the FSM SHALL go to TRAP with cause 1.
REQ-009 In EXECUTE, the ALU class SHALL go to WB.
REQ-010 In EXECUTE, JMP SHALL pulse jump and pc_load for 1 cycle and then go to FETCH.
REQ-011 In EXECUTE, BEQ and BNE SHALL pulse branch for 1 cycle, and then go to FETCH.
REQ-012 In EXECUTE, pc_load SHALL pulse only when (BEQ and zero=1) or (BNE and zero=0).
REQ-013 In EXECUTE, CALL SHALL pulse call and pc_load and increment depth, then go to FETCH; if depth==STACK_DEPTH, it SHALL instead go to TRAP with cause 2 and assert no pulses.
REQ-014 In EXECUTE, RET SHALL pulse ret and pc_load and decrement depth, then go to FETCH; if depth==0, it SHALL instead go to TRAP with cause 3 and assert no pulses.
REQ-015 In EXECUTE, LD and ST SHALL go to MEM.
REQ-016 In MEM, memoryRead (LD) or memoryWrite (ST) SHALL be held high continuously until the cycle in which mem_ready=1, inclusive.
REQ-017 On completion of MEM, LD SHALL go to WB and ST SHALL go to FETCH; the FSM SHALL wait in MEM indefinitely while mem_ready=0.
REQ-018 WB SHALL pulse regWrite for exactly 1 cycle and then go to FETCH; only the ALU class and LD SHALL ever assert regWrite.
REQ-019 retired SHALL increment by 1, modulo 2^CNT_W, on every transition into FETCH from EXECUTE, MEM or WB.
REQ-020 TRAP SHALL be absorbing: all pulse outputs 0, instr_ready=0, trap=1, and trap_cause held until reset.
REQ-021 Inputs sampled outside their defined state (instr_valid outside FETCH, mem_ready outside MEM) SHALL be ignored.
REQ-022 The minimum latency per instruction class SHALL be:
- JMP, branch, CALL, RET: 3 cycles.
- ALU: 4 cycles.
- ST: 4 cycles.
- LD: 5 cycles.

Reset
REQ-023 When reset=1 at a clock edge, the following SHALL hold from any state, including mid-MEM:
- State SHALL be FETCH.
- depth, retired and trap_cause SHALL be 0.
- trap SHALL be 0.
- All pulse outputs and memory requests SHALL be 0 in the following cycle.
- instr_ready SHALL be 1 in the following cycle.
REQ-024 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-025 Package ctrl_pkg SHALL hold the state enum, the opcode constants 0-20 and the trap_cause codes.
REQ-026 The call-depth up/down counter with overflow/underflow detection SHALL be a separate sub-module named call_depth_counter, parametrised by STACK_DEPTH.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- ADD (opcode 0) with instr_valid=1 -> ir_write at cycle 1, regWrite at cycle 4 only, retired=1.
- LD (19) with mem_ready held low for 3 cycles -> memoryRead high for 4 cycles, then regWrite 1 cycle, total 8 cycles.
- BEQ (15) with zero=0, then BNE (16) with zero=0 -> branch pulses twice, pc_load only on BNE.
- With STACK_DEPTH=2, issue three CALLs -> depth=2, trap=1, trap_cause=2; then a RET is ignored; reset -> depth=0, trap=0.
- Opcode 31 -> TRAP with cause 1, and no regWrite, memoryRead or memoryWrite.
- Assert reset while in MEM with memoryWrite high -> memoryWrite=0 and instr_ready=1 in the next cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit: FSM states,
// instruction classes, opcode map and trap cause codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_TRAP    = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CL_ALU, CL_JMP, CL_BEQ, CL_BNE, CL_CALL, CL_RET, CL_LD, CL_ST, CL_ILLEGAL
  } class_e;

  // Opcode map: 0..13 are ALU operations, 14..20 control/memory ops.
  localparam int unsigned OP_ALU_FIRST = 0;
  localparam int unsigned OP_ALU_LAST  = 13;
  localparam int unsigned OP_JMP       = 14;
  localparam int unsigned OP_BEQ       = 15;
  localparam int unsigned OP_BNE       = 16;
  localparam int unsigned OP_CALL      = 17;
  localparam int unsigned OP_RET       = 18;
  localparam int unsigned OP_LD        = 19;
  localparam int unsigned OP_ST        = 20;

  localparam logic [1:0] CAUSE_NONE      = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL   = 2'd1;
  localparam logic [1:0] CAUSE_OVERFLOW  = 2'd2;
  localparam logic [1:0] CAUSE_UNDERFLOW = 2'd3;

  // Map a zero-extended opcode onto its instruction class.
  function automatic class_e classify(input int unsigned op);
    class_e c;
    if (op <= OP_ALU_LAST) c = CL_ALU;
    else if (op == OP_JMP)  c = CL_JMP;
    else if (op == OP_BEQ)  c = CL_BEQ;
    else if (op == OP_BNE)  c = CL_BNE;
    else if (op == OP_CALL) c = CL_CALL;
    else if (op == OP_RET)  c = CL_RET;
    else if (op == OP_LD)   c = CL_LD;
    else if (op == OP_ST)   c = CL_ST;
    else                    c = CL_ILLEGAL;
    return c;
  endfunction

endpackage

// File: rtl/call_depth_counter.sv
// Saturating call-depth counter; full/empty flag the overflow and
// underflow conditions so the FSM can trap instead of pushing/popping.
module call_depth_counter #(
  parameter int STACK_DEPTH = 8,
  localparam int DW = $clog2(STACK_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] depth_q, depth_d;

  assign full  = (depth_q == DW'(STACK_DEPTH));
  assign empty = (depth_q == '0);
  assign depth = depth_q;

  // Next depth: push/pop are ignored at the limits so the count never wraps.
  always_comb begin
    depth_d = depth_q;
    if (push && !full)       depth_d = depth_q + DW'(1);
    else if (pop && !empty)  depth_d = depth_q - DW'(1);
  end

  // Depth register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) depth_q <= '0;
    else       depth_q <= depth_d;
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM: FETCH -> DECODE -> EXECUTE -> [MEM] -> [WB].
// All control outputs are decoded from the current state (plus the
// inputs that state is allowed to look at); faults park the FSM in TRAP.
// OPCODE_W must be >= 5 and STACK_DEPTH >= 1.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 5,
  parameter int STACK_DEPTH = 8,
  parameter int CNT_W       = 16,
  localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                instr_ready,
  output logic                ir_write,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                regWrite,
  output logic                memoryRead,
  output logic                memoryWrite,
  output logic                branch,
  output logic                jump,
  output logic                call,
  output logic                ret,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [DEPTH_W-1:0]  depth,
  output logic [CNT_W-1:0]    retired,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [1:0]          cause_q, cause_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                push, pop, stack_full, stack_empty, retire;
  class_e              cls;

  assign cls        = classify(32'(opcode_q));
  assign trap       = (state_q == ST_TRAP);
  assign busy       = (state_q != ST_FETCH);
  assign trap_cause = cause_q;
  assign retired    = retired_q;

  call_depth_counter #(.STACK_DEPTH(STACK_DEPTH)) u_depth (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .depth (depth),
    .full  (stack_full),
    .empty (stack_empty)
  );

  // FSM next state and per-state control decode.
  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    cause_d     = cause_q;
    instr_ready = 1'b0;
    ir_write    = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    regWrite    = 1'b0;
    memoryRead  = 1'b0;
    memoryWrite = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    call        = 1'b0;
    ret         = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    case (state_q)
      ST_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_write = 1'b1;
          pc_inc   = 1'b1;
          opcode_d = opcode;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (cls == CL_ILLEGAL) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        state_d = ST_FETCH;
        case (cls)
          CL_ALU: state_d = ST_WB;
          CL_JMP: begin jump = 1'b1; pc_load = 1'b1; end
          CL_BEQ: begin branch = 1'b1; pc_load = zero; end
          CL_BNE: begin branch = 1'b1; pc_load = ~zero; end
          CL_CALL: begin
            // A full stack traps before any side effect is signalled.
            if (stack_full) begin
              state_d = ST_TRAP;
              cause_d = CAUSE_OVERFLOW;
            end else begin
              call = 1'b1; pc_load = 1'b1; push = 1'b1;
            end
          end
          CL_RET: begin
            if (stack_empty) begin
              state_d = ST_TRAP;
              cause_d = CAUSE_UNDERFLOW;
            end else begin
              ret = 1'b1; pc_load = 1'b1; pop = 1'b1;
            end
          end
          CL_LD, CL_ST: state_d = ST_MEM;
          default: begin
            state_d = ST_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_MEM: begin
        // Request stays up through the cycle mem_ready is seen.
        memoryRead  = (cls == CL_LD);
        memoryWrite = (cls == CL_ST);
        if (mem_ready) state_d = (cls == CL_LD) ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        regWrite = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
    retire    = (state_d == ST_FETCH) &&
                (state_q inside {ST_EXECUTE, ST_MEM, ST_WB});
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  // State registers; reset wins over every other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      opcode_q  <= '0;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: instruction-level reference model expands each
// instruction into its expected per-cycle output trace; a directed table
// checks latencies/pulse counts, then randomized instruction streams.
module tb_multicycle_control_unit;

  localparam int SD = 2;
  localparam int CW = 4;

  logic       clk = 1'b0;
  logic       reset, instr_valid, zero, mem_ready;
  logic [4:0] opcode;
  logic       instr_ready, ir_write, pc_inc, pc_load, regWrite, memoryRead;
  logic       memoryWrite, branch, jump, call, ret, trap, busy;
  logic [1:0] trap_cause;
  logic [1:0] depth;
  logic [CW-1:0] retired;

  multicycle_control_unit #(.OPCODE_W(5), .STACK_DEPTH(SD), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
    .zero(zero), .mem_ready(mem_ready), .instr_ready(instr_ready),
    .ir_write(ir_write), .pc_inc(pc_inc), .pc_load(pc_load),
    .regWrite(regWrite), .memoryRead(memoryRead), .memoryWrite(memoryWrite),
    .branch(branch), .jump(jump), .call(call), .ret(ret), .trap(trap),
    .trap_cause(trap_cause), .depth(depth), .retired(retired), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic instr_ready, ir_write, pc_inc, pc_load, reg_write, mem_read;
    logic mem_write, branch, jump, call, ret, trap, busy;
    logic [1:0] cause;
    logic [7:0] depth;
    logic [7:0] retired;
  } obs_t;

  // offer: 0 drive instr_valid=0, 1 offer op, 2 random. mr: 0/1 fixed, 2 random.
  typedef struct { obs_t o; int offer; logic [4:0] op; logic z; int mr; } cyc_t;

  typedef struct {
    logic [4:0] op; logic z; int w;
    int lat, rw, pcl, br, mrd, mwr, dep, cause, ret;
  } vec_t;

  int   n_vec = 0, n_bad = 0;
  int   m_depth, m_retired, m_cause;
  int   c_lat, c_rw, c_pcl, c_br, c_mrd, c_mwr;
  cyc_t q[$];
  vec_t tbl[16];
  string ctx;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%s]: got %h expected %h", nm, ctx, act, exp);
    end
  endtask

  function automatic obs_t mk();
    obs_t o = '0;
    o.busy    = 1'b1;
    o.cause   = 2'(m_cause);
    o.depth   = 8'(m_depth);
    o.retired = 8'(m_retired);
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.instr_ready = instr_ready; o.ir_write = ir_write; o.pc_inc = pc_inc;
    o.pc_load = pc_load; o.reg_write = regWrite; o.mem_read = memoryRead;
    o.mem_write = memoryWrite; o.branch = branch; o.jump = jump;
    o.call = call; o.ret = ret; o.trap = trap; o.busy = busy;
    o.cause = trap_cause; o.depth = 8'(depth); o.retired = 8'(retired);
    return o;
  endfunction

  function automatic void qpush(obs_t o, int offer, logic [4:0] op, logic z, int mr);
    cyc_t c;
    c.o = o; c.offer = offer; c.op = op; c.z = z; c.mr = mr;
    q.push_back(c);
  endfunction

  function automatic void push_idle();
    obs_t o = mk();
    o.instr_ready = 1'b1; o.busy = 1'b0;
    qpush(o, 0, 5'd0, 1'b0, 2);
  endfunction

  function automatic void push_trap(logic [4:0] op, logic z);
    obs_t o;
    for (int i = 0; i < 2; i++) begin
      o = mk(); o.trap = 1'b1;
      qpush(o, 2, op, z, 2);
    end
  endfunction

  // Reference model: expand one instruction into its expected cycle trace.
  function automatic void build(logic [4:0] op, logic z, int w);
    obs_t o;
    o = mk(); o.instr_ready = 1'b1; o.ir_write = 1'b1; o.pc_inc = 1'b1; o.busy = 1'b0;
    qpush(o, 1, op, z, 2);
    o = mk();
    qpush(o, 2, op, z, 2);
    if (op > 5'd20) begin m_cause = 1; push_trap(op, z); return; end
    o = mk();
    if (op <= 5'd13) begin
      qpush(o, 2, op, z, 2);
      o = mk(); o.reg_write = 1'b1; qpush(o, 2, op, z, 2);
    end else begin
      case (op)
        5'd14: begin o.jump = 1'b1; o.pc_load = 1'b1; qpush(o, 2, op, z, 2); end
        5'd15, 5'd16: begin
          o.branch = 1'b1; o.pc_load = (op == 5'd15) ? z : !z;
          qpush(o, 2, op, z, 2);
        end
        5'd17: begin
          if (m_depth == SD) begin
            qpush(o, 2, op, z, 2); m_cause = 2; push_trap(op, z); return;
          end
          o.call = 1'b1; o.pc_load = 1'b1; qpush(o, 2, op, z, 2); m_depth++;
        end
        5'd18: begin
          if (m_depth == 0) begin
            qpush(o, 2, op, z, 2); m_cause = 3; push_trap(op, z); return;
          end
          o.ret = 1'b1; o.pc_load = 1'b1; qpush(o, 2, op, z, 2); m_depth--;
        end
        default: begin
          qpush(o, 2, op, z, 2);
          for (int i = 0; i <= w; i++) begin
            o = mk();
            if (op == 5'd19) o.mem_read = 1'b1; else o.mem_write = 1'b1;
            qpush(o, 2, op, z, (i == w) ? 1 : 0);
          end
          if (op == 5'd19) begin
            o = mk(); o.reg_write = 1'b1; qpush(o, 2, op, z, 2);
          end
        end
      endcase
    end
    m_retired = (m_retired + 1) % (1 << CW);
  endfunction

  // Apply n queued cycles: drive after posedge, compare at negedge.
  task automatic run(int n);
    cyc_t c; obs_t s;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      instr_valid = (c.offer == 1) ? 1'b1 : (c.offer == 0) ? 1'b0 : 1'($urandom);
      opcode      = (c.offer == 1) ? c.op : 5'($urandom);
      zero        = c.z;
      mem_ready   = (c.mr == 2) ? 1'($urandom) : 1'(c.mr);
      @(negedge clk);
      s = sample();
      check("cycle", 64'(s), 64'(c.o));
      if (!s.trap) c_lat++;
      c_rw  += int'(s.reg_write);
      c_pcl += int'(s.pc_load);
      c_br  += int'(s.branch);
      c_mrd += int'(s.mem_read);
      c_mwr += int'(s.mem_write);
      @(posedge clk); #1;
    end
  endtask

  // Reset with mem_ready high to show reset beats a completing access.
  task automatic do_reset();
    reset = 1'b1; instr_valid = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_depth = 0; m_retired = 0; m_cause = 0;
    q.delete();
    ctx = "after reset";
    push_idle();
    run(1);
  endtask

  initial begin
    // op z w lat rw pcl br mrd mwr dep cause ret
    tbl[0]  = '{5'd0,  1'b0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 1};
    tbl[1]  = '{5'd19, 1'b0, 3, 8, 1, 0, 0, 4, 0, 0, 0, 2};
    tbl[2]  = '{5'd15, 1'b0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 3};
    tbl[3]  = '{5'd16, 1'b0, 0, 3, 0, 1, 1, 0, 0, 0, 0, 4};
    tbl[4]  = '{5'd20, 1'b1, 2, 6, 0, 0, 0, 0, 3, 0, 0, 5};
    tbl[5]  = '{5'd14, 1'b0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 6};
    tbl[6]  = '{5'd17, 1'b0, 0, 3, 0, 1, 0, 0, 0, 1, 0, 7};
    tbl[7]  = '{5'd17, 1'b1, 0, 3, 0, 1, 0, 0, 0, 2, 0, 8};
    tbl[8]  = '{5'd17, 1'b0, 0, 3, 0, 0, 0, 0, 0, 2, 2, 8};
    tbl[9]  = '{5'd31, 1'b0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[10] = '{5'd18, 1'b0, 0, 3, 0, 0, 0, 0, 0, 0, 3, 0};
    tbl[11] = '{5'd17, 1'b0, 0, 3, 0, 1, 0, 0, 0, 1, 0, 1};
    tbl[12] = '{5'd15, 1'b1, 0, 3, 0, 1, 1, 0, 0, 1, 0, 2};
    tbl[13] = '{5'd18, 1'b0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 3};
    tbl[14] = '{5'd13, 1'b1, 0, 4, 1, 0, 0, 0, 0, 0, 0, 4};
    tbl[15] = '{5'd19, 1'b1, 0, 5, 1, 0, 0, 1, 0, 0, 0, 5};

    reset = 1'b1; instr_valid = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    m_depth = 0; m_retired = 0; m_cause = 0;
    ctx = "initial reset";
    push_idle();
    run(1);

    // Directed table: latency and pulse counts measured on the DUT.
    for (int i = 0; i < 16; i++) begin
      ctx = $sformatf("tbl%0d op%0d", i, tbl[i].op);
      c_lat = 0; c_rw = 0; c_pcl = 0; c_br = 0; c_mrd = 0; c_mwr = 0;
      build(tbl[i].op, tbl[i].z, tbl[i].w);
      run(q.size());
      check("latency",    64'(c_lat), 64'(tbl[i].lat));
      check("regwrite_n", 64'(c_rw),  64'(tbl[i].rw));
      check("pcload_n",   64'(c_pcl), 64'(tbl[i].pcl));
      check("branch_n",   64'(c_br),  64'(tbl[i].br));
      check("memread_n",  64'(c_mrd), 64'(tbl[i].mrd));
      check("memwrite_n", 64'(c_mwr), 64'(tbl[i].mwr));
      check("depth",      64'(depth), 64'(tbl[i].dep));
      check("trap_cause", 64'(trap_cause), 64'(tbl[i].cause));
      check("trap",       64'(trap), 64'(tbl[i].cause != 0));
      check("retired",    64'(retired), 64'(tbl[i].ret));
      if (tbl[i].cause != 0) begin
        // TRAP ignores further instructions, e.g. a RET offered here.
        for (int k = 0; k < 3; k++) begin
          instr_valid = 1'b1; opcode = 5'd18; mem_ready = 1'b1;
          @(negedge clk);
          check("trap_ret",   64'(ret),         64'd0);
          check("trap_rdy",   64'(instr_ready), 64'd0);
          check("trap_depth", 64'(depth),       64'(tbl[i].dep));
          check("trap_hold",  64'({trap, trap_cause}), 64'({1'b1, 2'(tbl[i].cause)}));
          @(posedge clk); #1;
        end
        do_reset();
        check("rst_depth", 64'(depth), 64'd0);
        check("rst_trap",  64'(trap),  64'd0);
      end
    end

    // Retired counter wraps modulo 2^CW.
    do_reset();
    ctx = "wrap";
    for (int i = 0; i < 17; i++) begin
      build(5'd0, 1'($urandom), 0);
      run(q.size());
    end
    check("retired_wrap", 64'(retired), 64'd1);

    // Reset while a store is waiting in MEM.
    ctx = "mid-mem";
    build(5'd20, 1'b0, 5);
    run(5);
    do_reset();

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      logic [4:0] op;
      ctx = $sformatf("rand%0d", n);
      for (int k = $urandom_range(0, 2); k > 0; k--) push_idle();
      if ($urandom_range(0, 99) < 5) op = 5'($urandom_range(21, 31));
      else                          op = 5'($urandom_range(0, 20));
      if (op == 5'd17 && m_depth == SD && $urandom_range(0, 9) < 8) op = 5'd18;
      if (op == 5'd18 && m_depth == 0  && $urandom_range(0, 9) < 8) op = 5'd17;
      build(op, 1'($urandom), $urandom_range(0, 3));
      run(q.size());
      if (m_cause != 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
